// File: rtl/audio_pkg.sv
// audio_pkg: shared audio-path constants and sample type.
//   L_DEF        default sample width (bits)
//   SLOT_DEF     default BCLK periods per channel slot
//   BCLK_DIV_DEF default clk cycles per BCLK period
//   FRAME_LEN    clk cycles per stereo frame at the defaults
//   sample_t     signed audio sample of L_DEF bits
package audio_pkg;

    localparam int unsigned L_DEF        = 24;
    localparam int unsigned SLOT_DEF     = 32;
    localparam int unsigned BCLK_DIV_DEF = 4;
    localparam int unsigned FRAME_LEN    = 2 * SLOT_DEF * BCLK_DIV_DEF;

    typedef logic signed [L_DEF-1:0] sample_t;

endpackage : audio_pkg

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: I2S timing generator (BCLK divider and slot bit counter).
//   clk, i_reset         system clock, synchronous active-high reset
//   o_bclk               bit clock (registered)
//   o_lrclk              word select, 1 = right slot (registered)
//   o_next_lrclk_fall    one-clk strobe in the cycle before lrclk falls (registered)
//   o_bit_adv_c          high in the last clk of each BCLK period (combinational)
//   o_slot_pos_c         slot position of the next cycle (combinational)
//   o_right_c            next cycle lies in the right slot (combinational)
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int unsigned SLOT     = SLOT_DEF,
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                      clk,
    input  logic                      i_reset,
    output logic                      o_bclk,
    output logic                      o_lrclk,
    output logic                      o_next_lrclk_fall,
    output logic                      o_bit_adv_c,
    output logic [$clog2(SLOT)-1:0]   o_slot_pos_c,
    output logic                      o_right_c
);

    localparam int unsigned DIV_W = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W = $clog2(2 * SLOT);
    localparam int unsigned POS_W = $clog2(SLOT);

    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [DIV_W-1:0] w_div_nxt;
    logic [BIT_W-1:0] w_bit_nxt;
    logic             w_bit_adv;
    logic             w_right_nxt;
    logic             r_bclk;
    logic             r_lrclk;
    logic             r_strobe;

    // Next counter values; outputs are registered from these so they move with the counters.
    always_comb begin
        w_bit_adv = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
        w_div_nxt = w_bit_adv ? '0 : r_div_cnt + DIV_W'(1);
        w_bit_nxt = r_bit_cnt;
        if (w_bit_adv) begin
            w_bit_nxt = (r_bit_cnt == BIT_W'(2 * SLOT - 1)) ? '0 : r_bit_cnt + BIT_W'(1);
        end
        w_right_nxt = (w_bit_nxt >= BIT_W'(SLOT));
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_bclk    <= (w_div_nxt >= DIV_W'(BCLK_DIV / 2));
            r_lrclk   <= w_right_nxt;
            r_strobe  <= (w_div_nxt == DIV_W'(BCLK_DIV - 1)) &&
                         (w_bit_nxt == BIT_W'(2 * SLOT - 1));
        end
    end

    assign o_bclk            = r_bclk;
    assign o_lrclk           = r_lrclk;
    assign o_next_lrclk_fall = r_strobe;
    assign o_bit_adv_c       = w_bit_adv;
    assign o_right_c         = w_right_nxt;
    // Slot position = bit_cnt mod SLOT, without assuming SLOT is a power of two.
    assign o_slot_pos_c      = w_right_nxt ? POS_W'(w_bit_nxt - BIT_W'(SLOT)) : POS_W'(w_bit_nxt);

endmodule : i2s_clkgen

// File: rtl/i2s_transmitter.sv
// i2s_transmitter: master-mode I2S transmitter, MSB-first, one-BCLK data delay.
//   clk, reset        system clock, synchronous active-high reset
//   left_in/right_in  signed samples, captured on the frame strobe
//   mute              load zeros instead of the inputs at capture
//   bclk, lrclk       bit clock and word select (0 = left)
//   sdata             serial data
//   next_lrclk_fall   one-clk frame strobe, the cycle before lrclk falls
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int unsigned L        = L_DEF,
    parameter int unsigned SLOT     = SLOT_DEF,
    parameter int unsigned BCLK_DIV = BCLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [L-1:0] left_in,
    input  logic signed [L-1:0] right_in,
    input  logic                mute,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                next_lrclk_fall
);

    localparam int unsigned POS_W = $clog2(SLOT);
    localparam int unsigned IDX_W = (L > 1) ? $clog2(L) : 1;

    logic signed [L-1:0] r_left;
    logic signed [L-1:0] r_right;
    logic                r_sdata;
    logic                w_strobe;
    logic                w_bit_adv;
    logic [POS_W-1:0]    w_pos;
    logic                w_right;
    logic [L-1:0]        w_word;
    logic [IDX_W-1:0]    w_idx;
    logic                w_sdata_nxt;

    i2s_clkgen #(
        .SLOT     (SLOT),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk               (clk),
        .i_reset           (reset),
        .o_bclk            (bclk),
        .o_lrclk           (lrclk),
        .o_next_lrclk_fall (w_strobe),
        .o_bit_adv_c       (w_bit_adv),
        .o_slot_pos_c      (w_pos),
        .o_right_c         (w_right)
    );

    // Bit for the next slot position: 0 at the delay bit and in the padding.
    always_comb begin
        w_word      = w_right ? r_right : r_left;
        w_idx       = '0;
        w_sdata_nxt = 1'b0;
        if ((w_pos != '0) && (w_pos <= POS_W'(L))) begin
            w_idx       = IDX_W'(POS_W'(L) - w_pos);
            w_sdata_nxt = w_word[w_idx];
        end
    end

    // Shadows load only on the strobe; sdata only moves at BCLK falling edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left  <= '0;
            r_right <= '0;
            r_sdata <= 1'b0;
        end else begin
            if (w_strobe) begin
                r_left  <= mute ? '0 : left_in;
                r_right <= mute ? '0 : right_in;
            end
            if (w_bit_adv) begin
                r_sdata <= w_sdata_nxt;
            end
        end
    end

    assign sdata           = r_sdata;
    assign next_lrclk_fall = w_strobe;

endmodule : i2s_transmitter
